count_seq_ctrl: RTL and testbench



---
 rtl/count_seq_ctrl.sv | 170 +++++++++++++++++
 tb/tb_count_seq_ctrl.sv | 266 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/count_seq_ctrl.sv
// count_seq_ctrl: sequencing controller for the user counter datapath.
// Takes LOAD_LIMIT / LOAD_PRESCALE / START / STOP commands, runs a prescaled
// counter from 0 up to a terminal limit, and reports tick, done and err.
// Optional build macro: DOWN_COUNT_EN (START cmd_data[1]=1 counts limit down to 0).
//
// Command handshake: a command transfers on a rising clk edge where
// cmd_valid && cmd_ready. cmd_ready is a register that is 0 after reset and 1
// from the first edge after reset release onward. Once it is 1 it stays 1, so
// every command transfers in one cycle. The producer holds cmd_op/cmd_data
// stable while cmd_valid is high.
module count_seq_ctrl #(
    parameter int CW = 8,
    parameter int PW = 8
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          ena,
    input  logic          cmd_valid,
    output logic          cmd_ready,
    input  logic [1:0]    cmd_op,
    input  logic [7:0]    cmd_data,
    output logic [CW-1:0] count,
    output logic          run,
    output logic          tick,
    output logic          done,
    output logic          err,
    output logic [1:0]    state_dbg
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    localparam logic [1:0] OP_LOAD_LIMIT = 2'b00;
    localparam logic [1:0] OP_LOAD_PRE   = 2'b01;
    localparam logic [1:0] OP_START      = 2'b10;
    localparam logic [1:0] OP_STOP       = 2'b11;

    state_t        state, state_nxt;
    logic [CW-1:0] limit;
    logic [PW-1:0] prescale;
    logic [PW-1:0] presc_cnt;
    logic          mode;

    logic          accept;
    logic          is_start, is_stop, is_load;
    logic          do_adv;
    logic          do_presc_inc;
    logic          at_term;
    logic [CW-1:0] start_val;
    logic [CW-1:0] reload_val;
    logic [CW-1:0] step_val;

    assign accept   = cmd_valid && cmd_ready;
    assign is_start = accept && (cmd_op == OP_START);
    assign is_stop  = accept && (cmd_op == OP_STOP);
    assign is_load  = accept && (cmd_op == OP_LOAD_LIMIT || cmd_op == OP_LOAD_PRE);

`ifdef DOWN_COUNT_EN
    logic dir_q;   // 1 = counting down towards 0

    assign at_term    = dir_q ? (count == '0) : (count == limit);
    assign start_val  = cmd_data[1] ? limit : '0;
    assign reload_val = dir_q ? limit : '0;
    assign step_val   = dir_q ? (count - CW'(1)) : (count + CW'(1));
`else
    assign at_term    = (count == limit);
    assign start_val  = '0;
    assign reload_val = '0;
    assign step_val   = count + CW'(1);
`endif

    assign run       = (state == S_RUN);
    assign state_dbg = state;

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next state and per-cycle strobes; START/STOP override any advance.
    always_comb begin
        state_nxt    = state;
        tick         = 1'b0;
        do_adv       = 1'b0;
        do_presc_inc = 1'b0;
        if (is_start) begin
            state_nxt = S_RUN;
        end else begin
            case (state)
                S_RUN: begin
                    if (is_stop) begin
                        state_nxt = S_IDLE;
                    end else if (ena) begin
                        if (presc_cnt == prescale) begin
                            do_adv = 1'b1;
                            if (at_term) begin
                                tick = 1'b1;
                                if (!mode) begin
                                    state_nxt = S_DONE;
                                end
                            end
                        end else begin
                            do_presc_inc = 1'b1;
                        end
                    end
                end
                default: state_nxt = state;
            endcase
        end
    end

    // Datapath registers, handshake ready and status flags.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cmd_ready <= 1'b0;
            count     <= '0;
            limit     <= '1;
            prescale  <= '0;
            presc_cnt <= '0;
            mode      <= 1'b0;
            done      <= 1'b0;
            err       <= 1'b0;
`ifdef DOWN_COUNT_EN
            dir_q     <= 1'b0;
`endif
        end else begin
            cmd_ready <= 1'b1;
            // Loads only land outside RUN; a load during RUN is flagged instead.
            if (is_load) begin
                if (state == S_RUN) begin
                    err <= 1'b1;
                end else if (cmd_op == OP_LOAD_LIMIT) begin
                    limit <= CW'(cmd_data);
                end else begin
                    prescale <= PW'(cmd_data);
                end
            end
            if (is_start) begin
                count     <= start_val;
                presc_cnt <= '0;
                mode      <= cmd_data[0];
                done      <= 1'b0;
`ifdef DOWN_COUNT_EN
                dir_q     <= cmd_data[1];
`endif
            end else if (do_adv) begin
                presc_cnt <= '0;
                if (at_term) begin
                    if (mode) begin
                        count <= reload_val;
                    end else begin
                        done <= 1'b1;   // one-shot: count holds at terminal value
                    end
                end else begin
                    count <= step_val;
                end
            end else if (do_presc_inc) begin
                presc_cnt <= presc_cnt + PW'(1);
            end
        end
    end

endmodule

// File: tb/tb_count_seq_ctrl.sv
// tb_count_seq_ctrl: directed checks of count_seq_ctrl with hand-computed values.
// Build with +define+DOWN_COUNT_EN to exercise the down-count step.
module tb_count_seq_ctrl;

    localparam int CW = 8;
    localparam int PW = 8;

    localparam logic [1:0] OP_LIM   = 2'b00;
    localparam logic [1:0] OP_PRE   = 2'b01;
    localparam logic [1:0] OP_START = 2'b10;
    localparam logic [1:0] OP_STOP  = 2'b11;

    logic          clk;
    logic          rst_n;
    logic          ena;
    logic          cmd_valid;
    logic          cmd_ready;
    logic [1:0]    cmd_op;
    logic [7:0]    cmd_data;
    logic [CW-1:0] count;
    logic          run;
    logic          tick;
    logic          done;
    logic          err;
    logic [1:0]    state_dbg;

    int n_assert = 0;
    int n_fail   = 0;

    count_seq_ctrl #(.CW(CW), .PW(PW)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .ena       (ena),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_op    (cmd_op),
        .cmd_data  (cmd_data),
        .count     (count),
        .run       (run),
        .tick      (tick),
        .done      (done),
        .err       (err),
        .state_dbg (state_dbg)
    );

    // Clock: 10 ns period.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Advance to 1 ns after the next rising edge.
    task automatic cyc(input int n = 1);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Present one command for a single accepting edge.
    task automatic send(input logic [1:0] op, input logic [7:0] data);
        cmd_valid = 1'b1;
        cmd_op    = op;
        cmd_data  = data;
        cyc();
        cmd_valid = 1'b0;
        cmd_op    = 2'b00;
        cmd_data  = 8'h00;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    int exp_c[12] = '{0, 0, 1, 1, 1, 0, 0, 0, 1, 1, 1, 0};
    int exp_t[12] = '{0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 1, 0};

    initial begin
        rst_n     = 1'b0;
        ena       = 1'b1;
        cmd_valid = 1'b0;
        cmd_op    = 2'b00;
        cmd_data  = 8'h00;

        // Reset state.
        #12;
        chk("rst_count", count, 0);
        chk("rst_run", run, 0);
        chk("rst_tick", tick, 0);
        chk("rst_done", done, 0);
        chk("rst_err", err, 0);
        chk("rst_ready", cmd_ready, 0);
        chk("rst_state", state_dbg, 0);
        cyc();
        rst_n = 1'b1;
        #1;
        chk("ready_first_cycle", cmd_ready, 0);
        cyc();
        chk("ready_after", cmd_ready, 1);

        // One-shot, limit 3, prescale 0.
        send(OP_LIM, 8'd3);
        chk("load_idle_no_err", err, 0);
        send(OP_PRE, 8'd0);
        send(OP_STOP, 8'd0);
        chk("stop_idle_noop", state_dbg, 0);
        send(OP_START, 8'd0);
        chk("os_start_count", count, 0);
        chk("os_start_run", run, 1);
        chk("os_start_tick", tick, 0);
        cyc();
        chk("os_c1", count, 1);
        chk("os_t1", tick, 0);
        cyc();
        chk("os_c2", count, 2);
        chk("os_t2", tick, 0);
        cyc();
        chk("os_c3", count, 3);
        chk("os_t3", tick, 1);
        chk("os_done_before", done, 0);
        cyc();
        chk("os_end_count", count, 3);
        chk("os_end_done", done, 1);
        chk("os_end_run", run, 0);
        chk("os_end_tick", tick, 0);
        chk("os_end_state", state_dbg, 2);
        cyc(2);
        chk("os_hold_count", count, 3);

        // Auto-reload, prescale 2, limit 1.
        send(OP_PRE, 8'd2);
        send(OP_LIM, 8'd1);
        send(OP_START, 8'd1);
        chk("ar_start_done_clr", done, 0);
        for (int k = 1; k <= 12; k++) begin
            cyc();
            chk($sformatf("ar_count_%0d", k), count, exp_c[k-1]);
            chk($sformatf("ar_tick_%0d", k), tick, exp_t[k-1]);
            chk($sformatf("ar_run_%0d", k), run, 1);
        end

        // Load during RUN: ignored, err sticky; limit stays 1.
        send(OP_LIM, 8'd9);
        chk("load_run_err", err, 1);
        chk("load_run_state", state_dbg, 1);
        cyc(5);
        chk("limit_kept_wrap", count, 0);
        chk("err_sticky1", err, 1);
        cyc(3);
        chk("pre_stop_count", count, 1);
        send(OP_STOP, 8'd0);
        chk("stop_run", run, 0);
        chk("stop_count", count, 1);
        chk("stop_err", err, 1);
        chk("stop_done", done, 0);
        cyc(3);
        chk("stop_frozen", count, 1);

        // ena freeze mid-run.
        send(OP_START, 8'd1);
        cyc();
        ena = 1'b0;
        cyc(5);
        chk("frz_count", count, 0);
        chk("frz_tick", tick, 0);
        ena = 1'b1;
        cyc();
        chk("res_c7", count, 0);
        cyc();
        chk("res_c8", count, 1);
        cyc();
        chk("res_t9", tick, 0);
        cyc();
        chk("res_t10", tick, 1);
        cyc();
        chk("res_c11", count, 0);
        chk("res_t11", tick, 0);

        // START in the exact cycle of a terminal advance.
        send(OP_STOP, 8'd0);
        send(OP_LIM, 8'd2);
        send(OP_PRE, 8'd0);
        send(OP_START, 8'd0);
        cyc(2);
        chk("term_count", count, 2);
        chk("term_tick_pre", tick, 1);
        cmd_valid = 1'b1;
        cmd_op    = OP_START;
        cmd_data  = 8'h00;
        #1;
        chk("start_supp_tick", tick, 0);
        cyc();
        cmd_valid = 1'b0;
        chk("restart_count", count, 0);
        chk("restart_done", done, 0);
        chk("restart_run", run, 1);
        cyc();
        chk("restart_c1", count, 1);

        // STOP in the terminal cycle suppresses the tick.
        cyc();
        chk("stop_term_count", count, 2);
        cmd_valid = 1'b1;
        cmd_op    = OP_STOP;
        #1;
        chk("stop_supp_tick", tick, 0);
        cyc();
        cmd_valid = 1'b0;
        chk("stop_term_done", done, 0);
        chk("stop_term_hold", count, 2);

        // Asynchronous reset mid-run.
        send(OP_START, 8'd1);
        cyc();
        chk("pre_arst_count", count, 1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_count", count, 0);
        chk("arst_run", run, 0);
        chk("arst_err", err, 0);
        chk("arst_ready", cmd_ready, 0);
        chk("arst_state", state_dbg, 0);
        cyc();
        rst_n = 1'b1;
        cyc();

        // START with cmd_data[1]=1, limit 4, prescale 0 (reset value).
        send(OP_LIM, 8'd4);
        send(OP_START, 8'h02);
`ifdef DOWN_COUNT_EN
        chk("dn_start", count, 4);
        cyc();
        chk("dn_c3", count, 3);
        cyc();
        chk("dn_c2", count, 2);
        cyc();
        chk("dn_c1", count, 1);
        cyc();
        chk("dn_c0", count, 0);
        chk("dn_tick", tick, 1);
        cyc();
        chk("dn_done", done, 1);
        chk("dn_run", run, 0);
        chk("dn_hold", count, 0);
`else
        chk("up_start", count, 0);
        cyc();
        chk("up_c1", count, 1);
        cyc(3);
        chk("up_c4", count, 4);
        chk("up_tick", tick, 1);
        cyc();
        chk("up_done", done, 1);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
